vend_dispense_ctrl: RTL

Downstream stage of the vending-machine state machine. It consumes the single-cycle "drink sold" and "0.5 rmb change owed" pulses and queues them. It then drives the drink-release motor and the change-coin ejector as timed, mutually exclusive actuator pulses, with an inter-action gap. It also keeps the lifetime sold counter and reports busy/overflow status to the display logic.

---
 rtl/vend_dispense_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vend_dispense_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vend_dispense_ctrl
// Description : Dispense back-end for the vending machine. Queues the
//               single-cycle "drink sold" and "0.5 rmb change owed" pulses,
//               then plays them out as timed, mutually exclusive actuator
//               pulses (drink motor / coin ejector), each followed by an idle
//               gap. Keeps the lifetime sold counter and reports busy and
//               overflow status to the display logic.
//
// Ports       : clk           - system clock
//               rst_n         - asynchronous active-low reset
//               i_vend        - one-cycle pulse, one drink to dispense
//               i_change      - one-cycle pulse, one 0.5 rmb coin to return
//               o_motor       - drink-release motor enable
//               o_coin_eject  - change ejector enable
//               o_busy        - not idle, or any request still queued
//               o_pend_vend   - queued drinks not yet started
//               o_pend_change - queued coins not yet started
//               o_sell_total  - drinks fully dispensed (wraps)
//               o_overflow    - sticky, a request was dropped at saturation
//
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES  = 1000,
  parameter int CHANGE_CYCLES = 500,
  parameter int GAP_CYCLES    = 100,
  parameter int PEND_W        = 3,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vend,
  input  logic              i_change,
  output logic              o_motor,
  output logic              o_coin_eject,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pend_vend,
  output logic [PEND_W-1:0] o_pend_change,
  output logic [CNT_W-1:0]  o_sell_total,
  output logic              o_overflow
);

  // --------------------------------------------------------------------------
  // Timer sizing: one down-counter shared by every timed state, wide enough
  // for the longest of the three durations.
  // --------------------------------------------------------------------------
  localparam int c_MAX_A   = (MOTOR_CYCLES > CHANGE_CYCLES) ? MOTOR_CYCLES : CHANGE_CYCLES;
  localparam int c_MAX_CYC = (c_MAX_A > GAP_CYCLES) ? c_MAX_A : GAP_CYCLES;
  localparam int c_TMR_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

  // The timer is loaded with N-1 on entry and the state is left on the edge
  // where it reads zero, giving exactly N cycles in the state.
  localparam logic [c_TMR_W-1:0] c_MOTOR_LD  = c_TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_CHANGE_LD = c_TMR_W'(CHANGE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LD    = c_TMR_W'(GAP_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ZERO  = '0;

  localparam logic [PEND_W-1:0]  c_PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0]  c_PEND_ZERO = '0;
  localparam logic [PEND_W-1:0]  c_PEND_ONE  = PEND_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);

  // One-hot state encoding, explicit 4-bit width.
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_MOTOR  = 4'b0010,
    S_CHANGE = 4'b0100,
    S_GAP    = 4'b1000
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_TMR_W-1:0] r_tmr;
  logic [c_TMR_W-1:0] w_tmr_nxt;

  logic [PEND_W-1:0]  r_pend_vend;
  logic [PEND_W-1:0]  r_pend_change;
  logic [CNT_W-1:0]   r_sell_total;
  logic               r_overflow;

  logic               w_tmr_zero;
  logic               w_vend_dec;   // a queued drink starts service this edge
  logic               w_chg_dec;    // a queued coin starts service this edge
  logic               w_sell_inc;   // a drink completes this edge
  logic               w_vend_drop;
  logic               w_chg_drop;

  assign w_tmr_zero = (r_tmr == c_TMR_ZERO);

  // --------------------------------------------------------------------------
  // State register and timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= c_TMR_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, timer and queue-service decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_vend_dec  = 1'b0;
    w_chg_dec   = 1'b0;
    w_sell_inc  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Drinks before change, so the customer gets the drink first.
        if (r_pend_vend != c_PEND_ZERO) begin
          w_state_nxt = S_MOTOR;
          w_tmr_nxt   = c_MOTOR_LD;
          w_vend_dec  = 1'b1;
        end else if (r_pend_change != c_PEND_ZERO) begin
          w_state_nxt = S_CHANGE;
          w_tmr_nxt   = c_CHANGE_LD;
          w_chg_dec   = 1'b1;
        end
      end

      S_MOTOR: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_GAP;
          w_tmr_nxt   = c_GAP_LD;
          w_sell_inc  = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end

      S_CHANGE: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_GAP;
          w_tmr_nxt   = c_GAP_LD;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end

      S_GAP: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = c_TMR_ZERO;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end

      default: begin
        // Not a legal one-hot code: recover to a quiet state.
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = c_TMR_ZERO;
      end
    endcase
  end

  // A pulse is dropped only when the queue is full and nothing leaves it on
  // the same edge; a simultaneous start frees the slot the pulse needs.
  assign w_vend_drop = i_vend   && !w_vend_dec && (r_pend_vend   == c_PEND_MAX);
  assign w_chg_drop  = i_change && !w_chg_dec  && (r_pend_change == c_PEND_MAX);

  // --------------------------------------------------------------------------
  // Pending queues, sold counter and sticky overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vend   <= c_PEND_ZERO;
      r_pend_change <= c_PEND_ZERO;
      r_sell_total  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      case ({i_vend, w_vend_dec})
        2'b10:   if (!w_vend_drop) r_pend_vend <= r_pend_vend + c_PEND_ONE;
        2'b01:   r_pend_vend <= r_pend_vend - c_PEND_ONE;
        default: r_pend_vend <= r_pend_vend;
      endcase

      case ({i_change, w_chg_dec})
        2'b10:   if (!w_chg_drop) r_pend_change <= r_pend_change + c_PEND_ONE;
        2'b01:   r_pend_change <= r_pend_change - c_PEND_ONE;
        default: r_pend_change <= r_pend_change;
      endcase

      // Natural modulo wrap; wrapping is not an overflow condition.
      if (w_sell_inc) r_sell_total <= r_sell_total + c_CNT_ONE;

      if (w_vend_drop || w_chg_drop) r_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Actuators decode straight from the state register so they drop
  // the instant reset is asserted and can never be high together.
  // --------------------------------------------------------------------------
  assign o_motor       = (r_state == S_MOTOR);
  assign o_coin_eject  = (r_state == S_CHANGE);
  assign o_busy        = (r_state != S_IDLE) || (r_pend_vend != c_PEND_ZERO) ||
                         (r_pend_change != c_PEND_ZERO);
  assign o_pend_vend   = r_pend_vend;
  assign o_pend_change = r_pend_change;
  assign o_sell_total  = r_sell_total;
  assign o_overflow    = r_overflow;

endmodule
`default_nettype wire
